// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular TX FIFO, with a sticky overflow
// flag and a TX-empty interrupt for the 6809 host.
module uart_tx_fifo #(
  parameter int CLOCK_DIVISOR = 4618,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_wr_en,
  input  logic [7:0] i_wr_data,
  input  logic       i_irq_en,
  input  logic       i_irq_ack,
  input  logic       i_ovf_clr,
  output logic       o_UART_RX,
  output logic [7:0] o_uart_status,
  output logic [4:0] o_count,
  output logic       o_IRQ
);
  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [12:0] LastTick = 13'(CLOCK_DIVISOR - 1);
  localparam logic [4:0]  DepthC   = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [12:0]   bitTimer_q, bitTimer_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txLine_q, txLine_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [4:0]    count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          irqPending_q, irqPending_d;
  logic          irqN_q;

  logic tick, fifoEmpty, fifoFull, pop, push, irqSet;

  assign tick      = (bitTimer_q == LastTick);
  assign fifoEmpty = (count_q == 5'd0);
  assign fifoFull  = (count_q == DepthC);
  // The FSM pops either from IDLE or at stop-bit expiry, so a full FIFO can
  // still accept a write on that exact cycle.
  assign pop       = !fifoEmpty && ((state_q == IDLE) || ((state_q == STOP) && tick));
  assign push      = i_wr_en && (!fifoFull || pop);
  assign irqSet    = (state_q == STOP) && tick && fifoEmpty && i_irq_en;

  always_comb begin
    state_d    = state_q;
    bitTimer_d = bitTimer_q + 13'd1;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    txLine_d   = txLine_q;
    case (state_q)
      IDLE: begin
        bitTimer_d = '0;
        if (pop) begin
          state_d  = START;
          shift_d  = mem_q[rdPtr_q];
          txLine_d = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d    = DATA;
          bitTimer_d = '0;
          bitIdx_d   = 3'd0;
          txLine_d   = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          bitTimer_d = '0;
          if (bitIdx_q == 3'd7) begin
            state_d  = STOP;
            txLine_d = 1'b1;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
            txLine_d = shift_q[bitIdx_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          bitTimer_d = '0;
          if (pop) begin
            state_d  = START;
            shift_d  = mem_q[rdPtr_q];
            txLine_d = 1'b0;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wrPtr_d = push ? wrPtr_q + PW'(1) : wrPtr_q;
    rdPtr_d = pop  ? rdPtr_q + PW'(1) : rdPtr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    overflow_d   = (i_wr_en && fifoFull && !pop) || (overflow_q && !i_ovf_clr);
    irqPending_d = irqSet || (irqPending_q && !i_irq_ack && !push);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bitTimer_q   <= '0;
      bitIdx_q     <= '0;
      shift_q      <= '0;
      txLine_q     <= 1'b1;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      irqPending_q <= 1'b0;
      irqN_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      bitTimer_q   <= bitTimer_d;
      bitIdx_q     <= bitIdx_d;
      shift_q      <= shift_d;
      txLine_q     <= txLine_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      irqPending_q <= irqPending_d;
      irqN_q       <= ~irqPending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= i_wr_data;
  end

  assign o_UART_RX     = txLine_q;
  assign o_count       = count_q;
  assign o_IRQ         = irqN_q;
  assign o_uart_status = {3'b000, irqPending_q, overflow_q, (state_q != IDLE), fifoFull, fifoEmpty};

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: line waveforms are compared against
// frames computed arithmetically from the bytes written.
module tb_uart_tx_fifo;
  localparam int Div      = 4;
  localparam int Depth    = 4;
  localparam int FrameLen = 10 * Div;

  logic       clk = 1'b0;
  logic       reset;
  logic       wrEn;
  logic [7:0] wrData;
  logic       irqEn;
  logic       irqAck;
  logic       ovfClr;
  logic       uartRx;
  logic [7:0] status;
  logic [4:0] count;
  logic       irqN;

  int passCount  = 0;
  int failCount  = 0;
  int totalCount = 0;

  logic       lineLog[$];
  logic [7:0] burstQ[$];

  uart_tx_fifo #(.CLOCK_DIVISOR(Div), .FIFO_DEPTH(Depth)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_wr_en      (wrEn),
    .i_wr_data    (wrData),
    .i_irq_en     (irqEn),
    .i_irq_ack    (irqAck),
    .i_ovf_clr    (ovfClr),
    .o_UART_RX    (uartRx),
    .o_uart_status(status),
    .o_count      (count),
    .o_IRQ        (irqN)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    lineLog.push_back(uartRx);
  endtask

  // Line level for each cycle of one 8N1 frame: start, bits 0..7, stop.
  function automatic logic [FrameLen-1:0] frameWave(input logic [7:0] b);
    logic [FrameLen-1:0] w;
    for (int c = 0; c < FrameLen; c++) begin
      int slot = c / Div;
      if (slot == 0)      w[c] = 1'b0;
      else if (slot <= 8) w[c] = b[slot-1];
      else                w[c] = 1'b1;
    end
    return w;
  endfunction

  task automatic checkFrames(input int start);
    logic [FrameLen-1:0] seen;
    for (int k = 0; k < burstQ.size(); k++) begin
      for (int c = 0; c < FrameLen; c++) seen[c] = lineLog[start + k*FrameLen + c];
      checkOutput($sformatf("frame%0d_byte%02h", k, burstQ[k]), 64'(seen), 64'(frameWave(burstQ[k])));
    end
    checkOutput("line_idle_after_frames", 64'(lineLog[start + burstQ.size()*FrameLen]), 64'd1);
  endtask

  // Writes burstQ on consecutive cycles from idle and checks the frames.
  task automatic applyStimulus();
    int n, peak, busyCycles, expPeak;
    n = burstQ.size();
    peak = 0;
    busyCycles = 0;
    lineLog.delete();
    for (int i = 0; i < n; i++) begin
      wrEn = 1'b1;
      wrData = burstQ[i];
      tick();
      if (int'(count) > peak) peak = int'(count);
      if (status[2]) busyCycles++;
    end
    wrEn = 1'b0;
    while (lineLog.size() < n*FrameLen + 2) begin
      tick();
      if (int'(count) > peak) peak = int'(count);
      if (status[2]) busyCycles++;
    end
    expPeak = (n == 1) ? 1 : n - 1;
    checkOutput("burst_peak_count", 64'(peak), 64'(expPeak));
    checkOutput("burst_busy_cycles", 64'(busyCycles), 64'(n*FrameLen));
    checkFrames(1);
    checkOutput("burst_status_idle", 64'(status), 64'h01);
  endtask

  initial begin
    int lows;
    reset = 1'b1; wrEn = 1'b0; wrData = 8'h00; irqEn = 1'b0; irqAck = 1'b0; ovfClr = 1'b0;
    tick(); tick();
    checkOutput("reset_line", 64'(uartRx), 64'd1);
    checkOutput("reset_status", 64'(status), 64'h01);
    checkOutput("reset_count", 64'(count), 64'd0);
    checkOutput("reset_irq", 64'(irqN), 64'd1);
    reset = 1'b0;
    tick();

    $display("[TB] single byte 0x55");
    burstQ = '{8'h55};
    applyStimulus();

    $display("[TB] four byte burst");
    burstQ = '{8'hA1, 8'h02, 8'hFF, 8'h80};
    applyStimulus();

    $display("[TB] random bursts");
    for (int r = 0; r < 4; r++) begin
      int n;
      burstQ.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) burstQ.push_back(8'($urandom));
      applyStimulus();
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("[TB] overflow");
    burstQ.delete();
    lineLog.delete();
    wrEn = 1'b1; wrData = 8'($urandom); burstQ.push_back(wrData);
    tick();
    wrEn = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      wrEn = 1'b1; wrData = 8'($urandom);
      if (i < 4) burstQ.push_back(wrData);
      tick();
    end
    wrEn = 1'b0;
    checkOutput("ovf_count_full", 64'(count), 64'd4);
    checkOutput("ovf_status_set", 64'(status), 64'h0E);
    ovfClr = 1'b1; tick(); ovfClr = 1'b0;
    checkOutput("ovf_status_cleared", 64'(status), 64'h06);
    wrEn = 1'b1; ovfClr = 1'b1; wrData = 8'($urandom); tick(); wrEn = 1'b0; ovfClr = 1'b0;
    checkOutput("ovf_set_beats_clear", 64'(status), 64'h0E);
    ovfClr = 1'b1; tick(); ovfClr = 1'b0;
    checkOutput("ovf_status_cleared2", 64'(status), 64'h06);
    while (lineLog.size() < 5*FrameLen + 2) tick();
    checkFrames(1);
    checkOutput("ovf_status_idle", 64'(status), 64'h01);

    $display("[TB] write on pop cycle while full");
    burstQ.delete();
    lineLog.delete();
    for (int i = 0; i < 5; i++) begin
      wrEn = 1'b1; wrData = 8'($urandom); burstQ.push_back(wrData);
      tick();
    end
    wrEn = 1'b0;
    while (lineLog.size() < FrameLen + 1) tick();
    checkOutput("full_before_pop", 64'(count), 64'd4);
    wrEn = 1'b1; wrData = 8'($urandom); burstQ.push_back(wrData);
    tick();
    wrEn = 1'b0;
    checkOutput("full_pop_count", 64'(count), 64'd4);
    checkOutput("full_pop_status", 64'(status), 64'h06);
    while (lineLog.size() < 6*FrameLen + 2) tick();
    checkFrames(1);
    checkOutput("full_pop_status_idle", 64'(status), 64'h01);

    $display("[TB] interrupt");
    irqEn = 1'b1;
    wrEn = 1'b1; wrData = 8'($urandom); tick(); wrEn = 1'b0;
    repeat (FrameLen) tick();
    checkOutput("irq_before_expiry", 64'(irqN), 64'd1);
    tick();
    checkOutput("irq_set", 64'(irqN), 64'd0);
    checkOutput("irq_status", 64'(status), 64'h11);
    irqAck = 1'b1; tick(); irqAck = 1'b0;
    checkOutput("irq_acked", 64'(irqN), 64'd1);
    wrEn = 1'b1; wrData = 8'($urandom); tick(); wrEn = 1'b0;
    repeat (FrameLen) tick();
    irqAck = 1'b1; tick(); irqAck = 1'b0;
    checkOutput("irq_set_beats_ack", 64'(irqN), 64'd0);
    irqEn = 1'b0; tick();
    checkOutput("irq_kept_after_disable", 64'(irqN), 64'd0);
    wrEn = 1'b1; wrData = 8'($urandom); tick(); wrEn = 1'b0;
    checkOutput("irq_cleared_by_write", 64'(irqN), 64'd1);
    repeat (FrameLen + 2) tick();
    checkOutput("irq_disabled_no_set", 64'(irqN), 64'd1);
    checkOutput("irq_disabled_status", 64'(status), 64'h01);

    $display("[TB] reset mid-frame");
    lineLog.delete();
    wrEn = 1'b1; wrData = 8'($urandom) & 8'hF7; tick();
    wrData = 8'($urandom); tick();
    wrData = 8'($urandom); tick();
    wrEn = 1'b0;
    checkOutput("queued_before_reset", 64'(count), 64'd2);
    while (lineLog.size() < 18) tick();
    checkOutput("bit3_low_before_reset", 64'(lineLog[17]), 64'd0);
    reset = 1'b1; tick();
    checkOutput("midreset_line", 64'(uartRx), 64'd1);
    checkOutput("midreset_count", 64'(count), 64'd0);
    checkOutput("midreset_status", 64'(status), 64'h01);
    checkOutput("midreset_irq", 64'(irqN), 64'd1);
    reset = 1'b0;
    lows = 0;
    repeat (100) begin
      tick();
      if (!uartRx) lows++;
    end
    checkOutput("post_reset_line_quiet", 64'(lows), 64'd0);
    checkOutput("post_reset_count", 64'(count), 64'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end
endmodule
